// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: opcodes, ALUop encodings and the
// control word carried from decode into the ID/EX register.
package riscv_pkg;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    typedef struct packed {
        logic       regWrite;
        logic       memToReg;
        logic       memRead;
        logic       memWrite;
        logic       aluSrc;
        logic       branch;
        logic [1:0] aluOp;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side inputs and EX-side registered outputs of the ID/EX boundary.
// The master drives decoded ID fields; the slave (the stage) drives EX.
interface id_ex_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic [XLEN-1:0]  PC_ID, IMM_ID, REG_DATA1_ID, REG_DATA2_ID;
    logic [2:0]       FUNCT3_ID;
    logic [6:0]       FUNCT7_ID, OPCODE_ID;
    logic [4:0]       RD_ID, RS1_ID, RS2_ID;
    logic             PCSrc;

    logic             PC_write, IF_ID_write, IF_ID_flush;
    logic [XLEN-1:0]  PC_EX, IMM_EX, REG_DATA1_EX, REG_DATA2_EX;
    logic [2:0]       FUNCT3_EX;
    logic [6:0]       FUNCT7_EX;
    logic [4:0]       RD_EX, RS1_EX, RS2_EX;
    logic             RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX;
    logic             ALUSrc_EX, Branch_EX, ILLEGAL_EX;
    logic [1:0]       ALUop_EX;
    logic [CNT_W-1:0] STALL_COUNT, FLUSH_COUNT;

    modport master (
        output PC_ID, IMM_ID, REG_DATA1_ID, REG_DATA2_ID, FUNCT3_ID, FUNCT7_ID,
               OPCODE_ID, RD_ID, RS1_ID, RS2_ID, PCSrc,
        input  PC_write, IF_ID_write, IF_ID_flush, PC_EX, IMM_EX, REG_DATA1_EX,
               REG_DATA2_EX, FUNCT3_EX, FUNCT7_EX, RD_EX, RS1_EX, RS2_EX,
               RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, ALUSrc_EX,
               Branch_EX, ILLEGAL_EX, ALUop_EX, STALL_COUNT, FLUSH_COUNT
    );

    modport slave (
        input  PC_ID, IMM_ID, REG_DATA1_ID, REG_DATA2_ID, FUNCT3_ID, FUNCT7_ID,
               OPCODE_ID, RD_ID, RS1_ID, RS2_ID, PCSrc,
        output PC_write, IF_ID_write, IF_ID_flush, PC_EX, IMM_EX, REG_DATA1_EX,
               REG_DATA2_EX, FUNCT3_EX, FUNCT7_EX, RD_EX, RS1_EX, RS2_EX,
               RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, ALUSrc_EX,
               Branch_EX, ILLEGAL_EX, ALUop_EX, STALL_COUNT, FLUSH_COUNT
    );

endinterface

// File: rtl/id_ex_stage_control_unit.sv
// Purely combinational main decoder: opcode to control word, plus which
// source registers the instruction actually reads.
module control_unit
    import riscv_pkg::*;
(
    input  logic [6:0] opcode_i,
    output ctrl_t      ctrl_o,
    output logic       usesRs1_o,
    output logic       usesRs2_o
);

    always_comb begin
        ctrl_o    = '0;
        usesRs1_o = 1'b0;
        usesRs2_o = 1'b0;
        case (opcode_i)
            OPC_RTYPE: begin
                ctrl_o.regWrite = 1'b1;
                ctrl_o.aluOp    = ALUOP_FUNCT;
                usesRs1_o       = 1'b1;
                usesRs2_o       = 1'b1;
            end
            OPC_ITYPE: begin
                ctrl_o.regWrite = 1'b1;
                ctrl_o.aluSrc   = 1'b1;
                ctrl_o.aluOp    = ALUOP_FUNCT;
                usesRs1_o       = 1'b1;
            end
            OPC_LOAD: begin
                ctrl_o.regWrite = 1'b1;
                ctrl_o.memToReg = 1'b1;
                ctrl_o.memRead  = 1'b1;
                ctrl_o.aluSrc   = 1'b1;
                ctrl_o.aluOp    = ALUOP_ADD;
                usesRs1_o       = 1'b1;
            end
            OPC_STORE: begin
                ctrl_o.memWrite = 1'b1;
                ctrl_o.aluSrc   = 1'b1;
                ctrl_o.aluOp    = ALUOP_ADD;
                usesRs1_o       = 1'b1;
                usesRs2_o       = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl_o.branch = 1'b1;
                ctrl_o.aluOp  = ALUOP_BRANCH;
                usesRs1_o     = 1'b1;
                usesRs2_o     = 1'b1;
            end
            default: ctrl_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline boundary: decode, load-use hazard detection, bubble
// injection on stall or branch flush, and saturating debug counters.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input logic           clk,
    input logic           reset,
    id_ex_stage_if.slave  bus
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        ctrl_t           ctrl;
    } ex_t;

    ctrl_t            ctrl;
    logic             usesRs1, usesRs2;
    logic             loadUse;
    ex_t              exD, exQ;
    logic [CNT_W-1:0] stallCntD, stallCntQ, flushCntD, flushCntQ;

    control_unit u_control_unit (
        .opcode_i  (bus.OPCODE_ID),
        .ctrl_o    (ctrl),
        .usesRs1_o (usesRs1),
        .usesRs2_o (usesRs2)
    );

    // x0 is never a real producer, so a load into x0 cannot create a hazard.
    assign loadUse = exQ.ctrl.memRead && (exQ.rd != 5'd0) &&
                     ((usesRs1 && (exQ.rd == bus.RS1_ID)) ||
                      (usesRs2 && (exQ.rd == bus.RS2_ID)));

    assign bus.PC_write    = bus.PCSrc || !loadUse;
    assign bus.IF_ID_write = bus.PCSrc || !loadUse;
    assign bus.IF_ID_flush = bus.PCSrc;

    // A taken branch outranks a stall; both load an all-zero bubble.
    always_comb begin
        exD       = '0;
        stallCntD = stallCntQ;
        flushCntD = flushCntQ;
        if (bus.PCSrc) begin
            if (!(&flushCntQ)) flushCntD = flushCntQ + 1'b1;
        end else if (loadUse) begin
            if (!(&stallCntQ)) stallCntD = stallCntQ + 1'b1;
        end else begin
            exD.pc     = bus.PC_ID;
            exD.imm    = bus.IMM_ID;
            exD.rd1    = bus.REG_DATA1_ID;
            exD.rd2    = bus.REG_DATA2_ID;
            exD.funct3 = bus.FUNCT3_ID;
            exD.funct7 = bus.FUNCT7_ID;
            exD.rd     = bus.RD_ID;
            exD.rs1    = bus.RS1_ID;
            exD.rs2    = bus.RS2_ID;
            exD.ctrl   = ctrl;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exQ       <= '0;
            stallCntQ <= '0;
            flushCntQ <= '0;
        end else begin
            exQ       <= exD;
            stallCntQ <= stallCntD;
            flushCntQ <= flushCntD;
        end
    end

    assign bus.PC_EX        = exQ.pc;
    assign bus.IMM_EX       = exQ.imm;
    assign bus.REG_DATA1_EX = exQ.rd1;
    assign bus.REG_DATA2_EX = exQ.rd2;
    assign bus.FUNCT3_EX    = exQ.funct3;
    assign bus.FUNCT7_EX    = exQ.funct7;
    assign bus.RD_EX        = exQ.rd;
    assign bus.RS1_EX       = exQ.rs1;
    assign bus.RS2_EX       = exQ.rs2;
    assign bus.RegWrite_EX  = exQ.ctrl.regWrite;
    assign bus.MemtoReg_EX  = exQ.ctrl.memToReg;
    assign bus.MemRead_EX   = exQ.ctrl.memRead;
    assign bus.MemWrite_EX  = exQ.ctrl.memWrite;
    assign bus.ALUSrc_EX    = exQ.ctrl.aluSrc;
    assign bus.Branch_EX    = exQ.ctrl.branch;
    assign bus.ALUop_EX     = exQ.ctrl.aluOp;
    assign bus.ILLEGAL_EX   = exQ.ctrl.illegal;
    assign bus.STALL_COUNT  = stallCntQ;
    assign bus.FLUSH_COUNT  = flushCntQ;

endmodule
